// File: rtl/level_load_ctrl.sv
// level_load_ctrl: copies one level's tile words from level ROM into the
// game-board register file, LANES words per cycle.
// Optional build macro LOAD_STALL_EN adds a mem_gnt input; ISSUE then only
// advances in granted cycles and each stall puts a bubble in the write path.
//
// state | meaning
// IDLE  | ready for a start request
// ISSUE | one ROM read per lane per (granted) cycle
// DRAIN | reads done, waiting RD_LAT cycles for the last ROM data
// DONE  | load finished (or rejected), held until start drops
module level_load_ctrl #(
  parameter int LANES  = 2,
  parameter int WORDS  = 30,
  parameter int LEVELS = 2,
  parameter int MEM_AW = 7,
  parameter int REG_AW = 6,
  parameter int RD_LAT = 1,
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LW-1:0]           level_sel,
  input  logic                    abort,
`ifdef LOAD_STALL_EN
  input  logic                    mem_gnt,
`endif
  output logic                    mem_rd_en,
  output logic [LANES*MEM_AW-1:0] mem_addr,
  output logic                    reg_we,
  output logic [LANES*REG_AW-1:0] reg_addr,
  output logic                    ready,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [LW-1:0]   level_q, level_d;
  logic            err_q, err_d;
  logic [2:0]      dcnt_q, dcnt_d;
  logic            gnt;
  logic            issue_fire;
  logic            abort_hit;
  logic            wr_vld;
  logic [CW-1:0]   wr_cnt;

`ifdef LOAD_STALL_EN
  assign gnt = mem_gnt;
`else
  assign gnt = 1'b1;
`endif

  assign issue_fire = (state_q == ISSUE) && gnt;
  assign abort_hit  = abort && ((state_q == ISSUE) || (state_q == DRAIN));

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      err_q   <= err_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state logic; drain timer is a down-counter ending at zero.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    level_d = level_q;
    err_d   = err_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (32'(level_sel) < LEVELS) begin
            level_d = level_sel;
            count_d = '0;
            err_d   = 1'b0;
            state_d = ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gnt) begin
          if (count_q == CW'(WORDS - 1)) begin
            state_d = (RD_LAT == 0) ? DONE : DRAIN;
            dcnt_d  = 3'(RD_LAT - 1);
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dcnt_q == 3'd0) begin
          state_d = DONE;
        end else begin
          dcnt_d = dcnt_q - 3'd1;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-side pipeline: valid bit and word index delayed by the ROM latency.
  generate
    if (RD_LAT == 0) begin : g_nolat
      assign wr_vld = issue_fire;
      assign wr_cnt = count_q;
    end else begin : g_lat
      logic [RD_LAT-1:0] pv_q;
      logic [CW-1:0]     pc_q [RD_LAT];

      // Shift {valid, count}; abort or reset flush every valid bit.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pv_q <= '0;
          for (int i = 0; i < RD_LAT; i++) pc_q[i] <= '0;
        end else begin
          pc_q[0] <= count_q;
          for (int i = 1; i < RD_LAT; i++) pc_q[i] <= pc_q[i-1];
          if (abort_hit) begin
            pv_q <= '0;
          end else begin
            pv_q[0] <= issue_fire;
            for (int i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
          end
        end
      end

      assign wr_vld = pv_q[RD_LAT-1];
      assign wr_cnt = pc_q[RD_LAT-1];
    end
  endgenerate

  // Lane addresses; zero whenever the matching strobe is low.
  always_comb begin
    mem_addr = '0;
    reg_addr = '0;
    for (int k = 0; k < LANES; k++) begin
      if (issue_fire)
        mem_addr[k*MEM_AW +: MEM_AW] =
          MEM_AW'(32'(level_q) * LANES * WORDS + k * WORDS + 32'(count_q));
      if (wr_vld)
        reg_addr[k*REG_AW +: REG_AW] = REG_AW'(k * WORDS + 32'(wr_cnt));
    end
  end

  assign mem_rd_en = issue_fire;
  assign reg_we    = wr_vld;
  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_level_load_ctrl.sv
// Directed bench for level_load_ctrl: default instance (a) and a
// LEVELS=3 / RD_LAT=3 instance (b). Expected outputs come from a small
// cycle model of the issue/write schedule inside run_load.
module tb_level_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, abort_a, start_b, abort_b;
  logic [0:0]  sel_a;
  logic [1:0]  sel_b;
`ifdef LOAD_STALL_EN
  logic        gnt_a, gnt_b;
`endif
  logic        rd_a, we_a, rdy_a, done_a, err_a;
  logic        rd_b, we_b, rdy_b, done_b, err_b;
  logic [13:0] maddr_a, maddr_b;
  logic [11:0] raddr_a, raddr_b;
  logic [30:0] obs_a, obs_b;

  int total = 0;
  int bad   = 0;

  assign obs_a = {rdy_a, done_a, err_a, rd_a, we_a, maddr_a, raddr_a};
  assign obs_b = {rdy_b, done_b, err_b, rd_b, we_b, maddr_b, raddr_b};

  level_load_ctrl u_a (
    .clk(clk), .reset(reset), .start(start_a), .level_sel(sel_a), .abort(abort_a),
`ifdef LOAD_STALL_EN
    .mem_gnt(gnt_a),
`endif
    .mem_rd_en(rd_a), .mem_addr(maddr_a), .reg_we(we_a), .reg_addr(raddr_a),
    .ready(rdy_a), .done(done_a), .err(err_a)
  );

  level_load_ctrl #(.LEVELS(3), .RD_LAT(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .level_sel(sel_b), .abort(abort_b),
`ifdef LOAD_STALL_EN
    .mem_gnt(gnt_b),
`endif
    .mem_rd_en(rd_b), .mem_addr(maddr_b), .reg_we(we_b), .reg_addr(raddr_b),
    .ready(rdy_b), .done(done_b), .err(err_b)
  );

  task automatic check_eq(input string tag, input logic [30:0] got, input logic [30:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] pack(input bit rdy, input bit dn, input bit er,
                                       input bit rd, input bit we, input int m0,
                                       input int m1, input int r0, input int r1);
    return {rdy, dn, er, rd, we, 7'(m1), 7'(m0), 6'(r1), 6'(r0)};
  endfunction

  task automatic drive(input bit which, input bit s, input logic [1:0] sel,
                       input bit ab, input bit g);
    if (which) begin
      start_b = s; sel_b = sel; abort_b = ab;
`ifdef LOAD_STALL_EN
      gnt_b = g;
`endif
    end else begin
      start_a = s; sel_a = sel[0]; abort_a = ab;
`ifdef LOAD_STALL_EN
      gnt_a = g;
`endif
    end
  endtask

  // One load on instance `which`, entered and left at #1 after a rising edge.
  task automatic run_load(input string tag, input bit which, input int level,
                          input int rdlat, input int abort_at, input int rst_at,
                          input bit stall, input bit ab_start);
    int sched[400];
    int issued = 0, issue_end = -1, m0, m1, r0, r1;
    bit in_issue = 1, aborted = 0, fin = 0, g, rd, we, dn;
    logic [30:0] exp, obs;
    for (int i = 0; i < 400; i++) sched[i] = -1;
    drive(which, 1'b1, 2'(level), ab_start, 1'b1);
    @(posedge clk); #1;
    for (int c = 1; c < 300; c++) begin
      g = stall ? (c % 2 == 1) : 1'b1;
      drive(which, !(abort_at > 0 && c >= abort_at), 2'(level ^ 1), c == abort_at, g);
      rd = !aborted && in_issue && g;
      m0 = rd ? level * 60 + issued : 0;
      m1 = rd ? m0 + 30 : 0;
      we = !aborted && sched[c] >= 0;
      r0 = we ? sched[c] : 0;
      r1 = we ? r0 + 30 : 0;
      dn = !aborted && issue_end >= 0 && c >= issue_end + rdlat + 1;
      exp = pack(aborted, dn, 1'b0, rd, we, m0, m1, r0, r1);
      @(negedge clk);
      obs = which ? obs_b : obs_a;
      check_eq($sformatf("%s c%0d", tag, c), obs, exp);
      if (c == rst_at) begin
        reset = 1'b0;
        #1;
        obs = which ? obs_b : obs_a;
        check_eq($sformatf("%s rst_async", tag), obs, pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(which, 1'b0, 2'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        obs = which ? obs_b : obs_a;
        check_eq($sformatf("%s rst_release", tag), obs, pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        return;
      end
      if (rd) begin
        sched[c + rdlat] = issued;
        issued++;
        if (issued == 30) begin
          in_issue = 0;
          issue_end = c;
        end
      end
      if (c == abort_at) aborted = 1;
      if (aborted && c == abort_at + 3) begin fin = 1; break; end
      if (issue_end >= 0 && c == issue_end + rdlat + 2) begin fin = 1; break; end
      @(posedge clk); #1;
    end
    check_eq($sformatf("%s ended", tag), {30'd0, fin}, 31'd1);
    @(posedge clk); #1;
    if (aborted) return;
    drive(which, 1'b0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    obs = which ? obs_b : obs_a;
    check_eq($sformatf("%s done_hold", tag), obs, pack(0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    @(negedge clk);
    obs = which ? obs_b : obs_a;
    check_eq($sformatf("%s ready_back", tag), obs, pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_a", obs_a, pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    check_eq("reset_b", obs_b, pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_a", obs_a, pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;

    run_load("a_lvl1", 1'b0, 1, 1, -1, -1, 1'b0, 1'b0);
    run_load("b_lat3", 1'b1, 0, 3, -1, -1, 1'b0, 1'b1);
    run_load("a_abort", 1'b0, 0, 1, 10, -1, 1'b0, 1'b0);
    run_load("a_after_abort", 1'b0, 1, 1, -1, -1, 1'b0, 1'b0);
    run_load("a_reset", 1'b0, 0, 1, -1, 15, 1'b0, 1'b0);
    run_load("a_after_reset", 1'b0, 0, 1, -1, -1, 1'b0, 1'b0);

    // Out-of-range level on the three-level instance.
    drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("err_done", obs_b, pack(0, 1, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("err_idle", obs_b, pack(1, 0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    run_load("b_lvl2_clr", 1'b1, 2, 3, -1, -1, 1'b0, 1'b0);

`ifdef LOAD_STALL_EN
    run_load("a_stall", 1'b0, 1, 1, -1, -1, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
